// File: rtl/axis_y_downsizer.sv
// axis_y_downsizer: serialises C*WY-bit array rows into AXI_WIDTH-bit AXI-Stream beats, lowest slice first
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast  wide row input, result j at bits [j*WY +: WY]
//   m_axis_tdata/tkeep/tvalid/tready/tlast  narrow slice output, tlast on final slice of final row
//   pkt_beats                     output beats sent in the current packet (saturating)
//   pkt_done                      one-cycle pulse the cycle after the tlast output handshake
module axis_y_downsizer #(
  parameter int C = 4,
  parameter int WY = 32,
  parameter int AXI_WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [C*WY-1:0]        s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [AXI_WIDTH-1:0]   m_axis_tdata,
  output logic [AXI_WIDTH/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [CNT_W-1:0]       pkt_beats,
  output logic                   pkt_done
);
  localparam int N = C * WY / AXI_WIDTH;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  if ((C * WY) % AXI_WIDTH != 0 || AXI_WIDTH % 8 != 0) begin : g_width_check
    $fatal(1, "axis_y_downsizer: C*WY must be a multiple of AXI_WIDTH, AXI_WIDTH a multiple of 8");
  end
  typedef enum logic {EMPTY, SEND} state_t;
  state_t state, state_n;
  logic [N-1:0][AXI_WIDTH-1:0] row;
  logic [KW-1:0] k;
  logic lastflag, up, fresh, k_end, in_hs, out_hs;
  assign k_end = k == K_LAST;
  assign m_axis_tvalid = state == SEND;
  // up keeps ready low through reset and rises on the first edge after release;
  // the next row may load on the same edge the final slice leaves
  assign s_axis_tready = up && (state == EMPTY || (k_end && m_axis_tready));
  assign m_axis_tlast = m_axis_tvalid && lastflag && k_end;
  assign m_axis_tkeep = '1;
  assign in_hs = s_axis_tvalid && s_axis_tready;
  assign out_hs = m_axis_tvalid && m_axis_tready;
  if (N == 1) begin : g_one
    assign m_axis_tdata = row[0];
  end else begin : g_many
    assign m_axis_tdata = row[k];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = in_hs ? SEND : (out_hs && k_end) ? EMPTY : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up <= 1'b0;
      row <= '0;
      lastflag <= 1'b0;
      k <= '0;
    end else begin
      up <= 1'b1;
      if (in_hs) begin
        row <= s_axis_tdata;
        lastflag <= s_axis_tlast;
        k <= '0;
      end else if (out_hs) begin
        k <= k_end ? '0 : k + 1'b1;
      end
    end
  end
  // fresh marks that the next output beat starts a new packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_beats <= '0;
      pkt_done <= 1'b0;
      fresh <= 1'b1;
    end else begin
      pkt_done <= out_hs && m_axis_tlast;
      if (out_hs) begin
        pkt_beats <= fresh ? CNT_W'(1) : pkt_beats + {{(CNT_W-1){1'b0}}, ~&pkt_beats};
        fresh <= m_axis_tlast;
      end
    end
  end
endmodule

// File: tb/tb_axis_y_downsizer.sv
// tb_axis_y_downsizer: random and directed stimulus against a queue-based slice model
module tb_axis_y_downsizer;
  typedef struct packed {logic [127:0] d; logic l;} ent_t;
  logic clk = 0;
  logic rst;
  logic [127:0] s_tdata;
  logic s_tlast, v0, v1, m_tready;
  logic r0, r1, mv0, mv1, ml0, ml1, pd0, pd1;
  logic [31:0] d0;
  logic [127:0] d1;
  logic [3:0] k0;
  logic [15:0] k1;
  logic [31:0] b0;
  logic [1:0] b1;
  int n_chk = 0, n_fail = 0;
  ent_t rows[$], expq[$];
  logic [31:0] mcnt[2];
  bit fresh[2], mdone[2];
  bit up, stalled;
  logic [127:0] pdata;
  logic plast;
  int vprob, rprob, cyc_n, nout, ndone, first_out, last_out;

  always #5 clk = ~clk;

  axis_y_downsizer u0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(v0), .s_axis_tready(r0), .s_axis_tlast(s_tlast),
    .m_axis_tdata(d0), .m_axis_tkeep(k0), .m_axis_tvalid(mv0), .m_axis_tready(m_tready),
    .m_axis_tlast(ml0), .pkt_beats(b0), .pkt_done(pd0)
  );
  axis_y_downsizer #(.AXI_WIDTH(128), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(v1), .s_axis_tready(r1), .s_axis_tlast(s_tlast),
    .m_axis_tdata(d1), .m_axis_tkeep(k1), .m_axis_tvalid(mv1), .m_axis_tready(m_tready),
    .m_axis_tlast(ml1), .pkt_beats(b1), .pkt_done(pd1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [127:0] d, input logic l);
    ent_t e;
    e.d = d;
    e.l = l;
    rows.push_back(e);
  endtask

  task automatic drive(input bit sel);
    bit v;
    v = rows.size() > 0 && $urandom_range(99) < vprob;
    v0 = !sel && v;
    v1 = sel && v;
    s_tdata = rows.size() > 0 ? rows[0].d : {$urandom, $urandom, $urandom, $urandom};
    s_tlast = rows.size() > 0 ? rows[0].l : 1'($urandom_range(1));
    m_tready = $urandom_range(99) < rprob;
  endtask

  // One clock: observe at negedge, update the model, then drive new inputs after the edge
  task automatic cyc(input bit sel);
    logic vld, lst, srdy, done, ivld;
    logic [127:0] data, mask;
    logic [31:0] beats, cmax;
    ent_t e, s;
    int n, w;
    @(negedge clk);
    vld = sel ? mv1 : mv0;
    lst = sel ? ml1 : ml0;
    srdy = sel ? r1 : r0;
    done = sel ? pd1 : pd0;
    ivld = sel ? v1 : v0;
    data = sel ? d1 : {96'b0, d0};
    beats = sel ? {30'b0, b1} : b0;
    n = sel ? 1 : 4;
    w = sel ? 128 : 32;
    mask = sel ? {128{1'b1}} : 128'hFFFF_FFFF;
    cmax = sel ? 32'd3 : 32'hFFFF_FFFF;
    if (stalled) begin
      chk("stall_valid", vld, 1);
      chk("stall_data", data, pdata);
      chk("stall_last", lst, plast);
    end
    chk("m_tvalid", vld, expq.size() > 0);
    chk("s_tready", srdy, up && (expq.size() == 0 || (expq.size() == 1 && m_tready)));
    chk("pkt_beats", beats, mcnt[sel]);
    chk("pkt_done", done, mdone[sel]);
    ndone += done;
    mdone[sel] = 0;
    if (vld && m_tready && expq.size() > 0) begin
      e = expq.pop_front();
      chk("tdata", data, e.d);
      chk("tlast", lst, e.l);
      mcnt[sel] = fresh[sel] ? 1 : (mcnt[sel] == cmax ? mcnt[sel] : mcnt[sel] + 1);
      fresh[sel] = e.l;
      mdone[sel] = e.l;
      if (nout == 0) first_out = cyc_n;
      last_out = cyc_n;
      nout++;
    end
    stalled = vld && !m_tready;
    pdata = data;
    plast = lst;
    if (ivld && srdy) begin
      e = rows.pop_front();
      for (int j = 0; j < n; j++) begin
        s.d = (e.d >> (j * w)) & mask;
        s.l = e.l && j == n - 1;
        expq.push_back(s);
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
    up = 1;
    drive(sel);
  endtask

  task automatic run(input bit sel, input int maxc);
    int c;
    c = 0;
    drive(sel);
    while ((rows.size() > 0 || expq.size() > 0) && c < maxc) begin
      cyc(sel);
      c++;
    end
    chk("drain", rows.size() + expq.size(), 0);
    cyc(sel);
  endtask

  task automatic rst_phase;
    rst = 1;
    v0 = 0;
    v1 = 0;
    rows.delete();
    expq.delete();
    mcnt = '{0, 0};
    fresh = '{1, 1};
    mdone = '{0, 0};
    stalled = 0;
    up = 0;
    @(negedge clk);
    chk("rst_s_tready", {r1, r0}, 0);
    chk("rst_m_tvalid", {mv1, mv0}, 0);
    chk("rst_m_tlast", {ml1, ml0}, 0);
    chk("rst_tdata0", d0, 0);
    chk("rst_tdata1", d1, 0);
    chk("rst_beats", {b1, b0}, 0);
    chk("rst_done", {pd1, pd0}, 0);
    chk("tkeep", {k1, k0}, 20'hFFFFF);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    rst = 1; v0 = 0; v1 = 0; s_tdata = 0; s_tlast = 0; m_tready = 1;
    vprob = 100; rprob = 100; cyc_n = 0; nout = 0; ndone = 0; first_out = 0; last_out = 0;
    rst_phase();
    // directed two-row packet at full rate
    add(128'h44444444_33333333_22222222_11111111, 0);
    add(128'h88888888_77777777_66666666_55555555, 1);
    run(0, 50);
    chk("dir_beats", b0, 8);
    chk("dir_done_pulses", ndone, 1);
    // random backpressure and input gaps
    vprob = 70; rprob = 50; ndone = 0;
    for (int i = 0; i < 6; i++) add({$urandom, $urandom, $urandom, $urandom}, i == 5);
    run(0, 400);
    chk("bp_beats", b0, 24);
    chk("bp_done_pulses", ndone, 1);
    // sustained full rate: 64 beats in 64 consecutive cycles
    vprob = 100; rprob = 100; nout = 0;
    for (int i = 0; i < 16; i++) add({$urandom, $urandom, $urandom, $urandom}, i == 15);
    run(0, 200);
    chk("fullrate_beats", nout, 64);
    chk("fullrate_span", last_out - first_out + 1, 64);
    chk("fullrate_pkt_beats", b0, 64);
    // back-to-back packets
    rprob = 80; ndone = 0;
    add({$urandom, $urandom, $urandom, $urandom}, 0);
    add({$urandom, $urandom, $urandom, $urandom}, 1);
    add({$urandom, $urandom, $urandom, $urandom}, 1);
    run(0, 200);
    chk("b2b_done_pulses", ndone, 2);
    chk("b2b_beats", b0, 4);
    // reset in the middle of a packet, then a fresh row
    rprob = 100;
    for (int i = 0; i < 3; i++) add({$urandom, $urandom, $urandom, $urandom}, i == 2);
    drive(0);
    for (int i = 0; i < 6; i++) cyc(0);
    rst_phase();
    add({$urandom, $urandom, $urandom, $urandom}, 1);
    run(0, 50);
    chk("post_rst_beats", b0, 4);
    // single-slice configuration with a 2-bit saturating counter
    ndone = 0;
    for (int i = 0; i < 3; i++) add({$urandom, $urandom, $urandom, $urandom}, i == 2);
    run(1, 50);
    chk("n1_beats", b1, 3);
    chk("n1_done_pulses", ndone, 1);
    rprob = 50; vprob = 70; ndone = 0;
    for (int i = 0; i < 5; i++) add({$urandom, $urandom, $urandom, $urandom}, i == 4);
    run(1, 300);
    chk("n1_sat_beats", b1, 3);
    chk("n1_sat_done_pulses", ndone, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
